// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and field widths.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OP_W-1:0] OP_MUL   = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOD   = 4'b0100;
    localparam logic [OP_W-1:0] OP_PASSA = 4'b0101;
    localparam logic [OP_W-1:0] OP_PASSB = 4'b0110;
    localparam logic [OP_W-1:0] OP_INC   = 4'b0111;
    localparam logic [OP_W-1:0] OP_DEC   = 4'b1000;
    localparam logic [OP_W-1:0] OP_CLR   = 4'b1001;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DONE
    } alu_state_t;

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock over WIDTH iterations.
// quotient/remainder are the values committed by the final iteration, valid while done=1.
module alu_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             q_bit;

    // quo shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dvsr});
        rem_nxt   = q_bit ? (rem_shift - {1'b0, dvsr}) : rem_shift;
        quo_nxt   = {quo[WIDTH-2:0], q_bit};
    end

    assign busy      = run;
    assign done      = run && (cnt == CNT_W'(1));
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
            cnt  <= '0;
            run  <= 1'b0;
        end else if (load) begin
            rem  <= '0;
            quo  <= dividend;
            dvsr <= divisor;
            cnt  <= CNT_W'(WIDTH);
            run  <= 1'b1;
        end else if (run) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle unsigned ALU: single-cycle arithmetic, shift-add multiply and sequential divide.
// state   | meaning
// IDLE    | waiting for start
// MUL_RUN | shift-add multiply, one multiplier bit per clock
// DIV_RUN | divider sub-block iterating
// DONE    | done pulse; a new start is accepted here
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c_bus,
    output logic [WIDTH-1:0] c_hi_bus,
    output logic             z_flag,
    output logic             c_flag,
    output logic             dz_flag
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_t         state;
    alu_state_t         state_nxt;
    logic [OP_W-1:0]    op_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;

    logic               accept;
    logic               mul_load;
    logic               div_load;
    logic               res_en;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               res_c;
    logic               res_dz;

    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    alu_seq_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .dividend  (a_bus),
        .divisor   (b_bus),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign busy = (state == MUL_RUN) || div_busy;
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mul_load  = 1'b0;
        div_load  = 1'b0;
        res_en    = 1'b0;
        res_lo    = '0;
        res_hi    = '0;
        res_c     = 1'b0;
        res_dz    = 1'b0;
        sum       = {1'b0, a_bus} + {1'b0, b_bus};
        acc_step  = mplier[0] ? (acc + mcand) : acc;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = DONE;
                    res_en    = 1'b1;
                    case (op)
                        OP_ADD:   {res_c, res_lo} = sum;
                        OP_SUB: begin
                            res_lo = a_bus - b_bus;
                            res_c  = (a_bus < b_bus);
                        end
                        OP_MUL: begin
                            res_en    = 1'b0;
                            mul_load  = 1'b1;
                            state_nxt = MUL_RUN;
                        end
                        OP_DIV, OP_MOD: begin
                            if (b_bus == '0) begin
                                res_dz = 1'b1;
                                res_lo = (op == OP_DIV) ? '1 : a_bus;
                            end else begin
                                res_en    = 1'b0;
                                div_load  = 1'b1;
                                state_nxt = DIV_RUN;
                            end
                        end
                        OP_PASSA: res_lo = a_bus;
                        OP_PASSB: res_lo = b_bus;
                        OP_INC:   res_lo = a_bus + 1'b1;
                        OP_DEC:   res_lo = a_bus - 1'b1;
                        OP_CLR:   res_lo = '0;
                        // unknown op completes without touching results or flags
                        default:  res_en = 1'b0;
                    endcase
                end
            end
            MUL_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    res_en    = 1'b1;
                    res_lo    = acc_step[WIDTH-1:0];
                    res_hi    = acc_step[2*WIDTH-1:WIDTH];
                    state_nxt = DONE;
                end
            end
            DIV_RUN: begin
                if (div_done) begin
                    res_en    = 1'b1;
                    res_lo    = (op_r == OP_DIV) ? div_quo : div_rem;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            c_bus    <= '0;
            c_hi_bus <= '0;
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
            dz_flag  <= 1'b0;
        end else begin
            if (accept) begin
                op_r <= op;
            end
            if (mul_load) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_bus};
                mplier <= b_bus;
                cnt    <= CNT_W'(WIDTH);
            end else if (state == MUL_RUN) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end
            if (res_en) begin
                c_bus    <= res_lo;
                c_hi_bus <= res_hi;
                z_flag   <= (res_lo == '0);
                c_flag   <= res_c;
                dz_flag  <= res_dz;
            end
        end
    end

endmodule
